// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the upstream issue logic and the ALU issue stage.
// The slave modport is the stage itself; the master modport is its environment.
interface alu_issue_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid_in;
  logic            in_ready_out;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic            out_valid_out;
  logic            out_ready_in;
  logic [3:0]      alu_op_out;
  logic [XLEN-1:0] op_1_out;
  logic [XLEN-1:0] op_2_out;
  logic [4:0]      rd_out;
  logic            illegal_out;

  modport master (
    output in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
    input  in_ready_out, out_valid_out, alu_op_out, op_1_out, op_2_out, rd_out,
    illegal_out
  );

  modport slave (
    input  in_valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in, out_ready_in,
    output in_ready_out, out_valid_out, alu_op_out, op_1_out, op_2_out, rd_out,
    illegal_out
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode-and-issue stage in front of the integer ALU: decodes OP/OP-IMM/
// LUI/AUIPC into {funct7[5],funct3}, selects operands, buffers in a 2-entry FIFO.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  alu_issue_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

  function automatic logic [XLEN-1:0] zext_shamt(input logic [4:0] shamt);
    return {{(XLEN-5){1'b0}}, shamt};
  endfunction

  function automatic logic [XLEN-1:0] upper_imm(input logic [19:0] imm);
    return {{(XLEN-32){imm[19]}}, imm, 12'b0};
  endfunction

  // Stage p0: combinational decode of the offered instruction
  logic [6:0] opcode_p0;
  logic [2:0] funct3_p0;
  logic [6:0] funct7_p0;
  entry_t     dec_p0;

  assign opcode_p0 = bus.instr_in[6:0];
  assign funct3_p0 = bus.instr_in[14:12];
  assign funct7_p0 = bus.instr_in[31:25];

  always_comb begin
    dec_p0         = '0;
    dec_p0.rd      = bus.instr_in[11:7];
    dec_p0.illegal = 1'b1;
    case (opcode_p0)
      OPC_OP: begin
        if (funct7_p0 == F7_ZERO ||
            (funct7_p0 == F7_ALT && (funct3_p0 == 3'b000 || funct3_p0 == 3'b101))) begin
          dec_p0.illegal = 1'b0;
          dec_p0.alu_op  = {bus.instr_in[30], funct3_p0};
          dec_p0.op1     = bus.rs1_data_in;
          dec_p0.op2     = bus.rs2_data_in;
        end
      end
      OPC_OP_IMM: begin
        case (funct3_p0)
          3'b001: begin
            if (funct7_p0 == F7_ZERO) begin
              dec_p0.illegal = 1'b0;
              dec_p0.alu_op  = 4'b0001;
              dec_p0.op1     = bus.rs1_data_in;
              dec_p0.op2     = zext_shamt(bus.instr_in[24:20]);
            end
          end
          3'b101: begin
            if (funct7_p0 == F7_ZERO || funct7_p0 == F7_ALT) begin
              dec_p0.illegal = 1'b0;
              dec_p0.alu_op  = {bus.instr_in[30], 3'b101};
              dec_p0.op1     = bus.rs1_data_in;
              dec_p0.op2     = zext_shamt(bus.instr_in[24:20]);
            end
          end
          default: begin
            dec_p0.illegal = 1'b0;
            dec_p0.alu_op  = {1'b0, funct3_p0};
            dec_p0.op1     = bus.rs1_data_in;
            dec_p0.op2     = sext_imm12(bus.instr_in[31:20]);
          end
        endcase
      end
      OPC_LUI: begin
        dec_p0.illegal = 1'b0;
        dec_p0.op2     = upper_imm(bus.instr_in[31:12]);
      end
      OPC_AUIPC: begin
        dec_p0.illegal = 1'b0;
        dec_p0.op1     = bus.pc_in;
        dec_p0.op2     = upper_imm(bus.instr_in[31:12]);
      end
      default: ;
    endcase
  end

  // Stage p1: 2-entry buffer, head always presented on the outputs
  entry_t     head_p1;
  entry_t     tail_p1;
  logic [1:0] count_p1;
  logic       push_p0;
  logic       pop_p1;

  // Ready depends only on the registered count, never on out_ready_in.
  assign bus.in_ready_out  = (count_p1 < 2'd2);
  assign bus.out_valid_out = (count_p1 != 2'd0);
  assign push_p0 = bus.in_valid_in && bus.in_ready_out;
  assign pop_p1  = bus.out_valid_out && bus.out_ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_p1 <= 2'd0;
      head_p1  <= '0;
      tail_p1  <= '0;
    end else if (flush_in) begin
      count_p1 <= 2'd0;
    end else begin
      case (count_p1)
        2'd0: begin
          if (push_p0) begin
            head_p1  <= dec_p0;
            count_p1 <= 2'd1;
          end
        end
        2'd1: begin
          if (push_p0 && pop_p1) begin
            head_p1 <= dec_p0;
          end else if (push_p0) begin
            tail_p1  <= dec_p0;
            count_p1 <= 2'd2;
          end else if (pop_p1) begin
            count_p1 <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_p1) begin
            head_p1  <= tail_p1;
            count_p1 <= 2'd1;
          end
        end
        default: count_p1 <= 2'd0;
      endcase
    end
  end

  assign bus.alu_op_out  = head_p1.alu_op;
  assign bus.op_1_out    = head_p1.op1;
  assign bus.op_2_out    = head_p1.op2;
  assign bus.rd_out      = head_p1.rd;
  assign bus.illegal_out = head_p1.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, illegal ordering,
// backpressure, flush and reset, each with hand-computed expectations.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_issue_stage_if #(.XLEN(32)) bus ();

  alu_issue_stage #(.XLEN(32)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .flush_in (flush),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // {valid, alu_op, op1, op2, rd, illegal}
  function automatic logic [74:0] head_vec();
    return {bus.out_valid_out, bus.alu_op_out, bus.op_1_out, bus.op_2_out,
            bus.rd_out, bus.illegal_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.in_valid_in = 1'b1;
    bus.instr_in    = instr;
    bus.pc_in       = pc;
  endtask

  task automatic test_reset();
    logic [75:0] exp_v;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_v = {1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0};
    checks++;
    if ({bus.in_ready_out, head_vec()} !== exp_v) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", {bus.in_ready_out, head_vec()}, exp_v);
    end
  endtask

  task automatic test_basic_decode();
    logic [74:0] exp_v;
    bus.out_ready_in = 1'b1;
    bus.rs1_data_in  = 32'd5;
    bus.rs2_data_in  = 32'd7;
    drive(32'h002081B3, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL add got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h402081B3, 32'h0);
    tick();
    exp_v = {1'b1, 4'b1000, 32'd5, 32'd7, 5'd3, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL sub got=%h exp=%h", head_vec(), exp_v);
    end
    bus.in_valid_in = 1'b0;
    tick();
    checks++;
    if (bus.out_valid_out !== 1'b0) begin
      errors++; $display("FAIL drain_after_sub got=%b exp=0", bus.out_valid_out);
    end
  endtask

  task automatic test_immediates();
    logic [74:0] exp_v;
    bus.out_ready_in = 1'b1;
    bus.rs1_data_in  = 32'd5;
    bus.rs2_data_in  = 32'd7;
    drive(32'hFFF00093, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL addi_neg got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h4032D293, 32'h0);
    tick();
    exp_v = {1'b1, 4'b1101, 32'd5, 32'd3, 5'd5, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL srai got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h00409093, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0001, 32'd5, 32'd4, 5'd1, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL slli got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h02009093, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd0, 32'd0, 5'd1, 1'b1};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL slli_bad_funct7 got=%h exp=%h", head_vec(), exp_v);
    end
    bus.in_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_upper_imm();
    logic [74:0] exp_v;
    bus.out_ready_in = 1'b1;
    bus.rs1_data_in  = 32'd5;
    drive(32'h123450B7, 32'h100);
    tick();
    exp_v = {1'b1, 4'b0000, 32'h0, 32'h12345000, 5'd1, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL lui got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h12345097, 32'h100);
    tick();
    exp_v = {1'b1, 4'b0000, 32'h100, 32'h12345000, 5'd1, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL auipc got=%h exp=%h", head_vec(), exp_v);
    end
    bus.in_valid_in = 1'b0;
    tick();
  endtask

  task automatic test_illegal_order();
    logic [74:0] exp_v;
    bus.out_ready_in = 1'b1;
    bus.rs1_data_in  = 32'd5;
    bus.rs2_data_in  = 32'd7;
    drive(32'h002081B3, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL illegal_seq_add got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h022081B3, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd0, 32'd0, 5'd3, 1'b1};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL illegal_seq_mul got=%h exp=%h", head_vec(), exp_v);
    end
    drive(32'h0000007F, 32'h0);
    tick();
    exp_v = {1'b1, 4'b0000, 32'd0, 32'd0, 5'd0, 1'b1};
    checks++;
    if (head_vec() !== exp_v) begin
      errors++; $display("FAIL illegal_seq_opc got=%h exp=%h", head_vec(), exp_v);
    end
    bus.in_valid_in = 1'b0;
    tick();
    checks++;
    if (bus.out_valid_out !== 1'b0) begin
      errors++; $display("FAIL illegal_seq_drain got=%b exp=0", bus.out_valid_out);
    end
  endtask

  task automatic test_backpressure();
    logic [74:0] exp_a, exp_b, exp_c;
    exp_a = {1'b1, 4'b0000, 32'd5, 32'd7, 5'd3, 1'b0};
    exp_b = {1'b1, 4'b0000, 32'd5, 32'hFFFFFFFF, 5'd1, 1'b0};
    exp_c = {1'b1, 4'b0000, 32'd0, 32'h12345000, 5'd1, 1'b0};
    bus.rs1_data_in  = 32'd5;
    bus.rs2_data_in  = 32'd7;
    bus.out_ready_in = 1'b0;
    drive(32'h002081B3, 32'h0);
    tick();
    drive(32'hFFF00093, 32'h0);
    checks++;
    if (bus.in_ready_out !== 1'b1) begin
      errors++; $display("FAIL bp_ready_second got=%b exp=1", bus.in_ready_out);
    end
    tick();
    drive(32'h123450B7, 32'h0);
    checks++;
    if ({bus.in_ready_out, head_vec()} !== {1'b0, exp_a}) begin
      errors++; $display("FAIL bp_full got=%h exp=%h", {bus.in_ready_out, head_vec()}, {1'b0, exp_a});
    end
    tick();
    checks++;
    if ({bus.in_ready_out, head_vec()} !== {1'b0, exp_a}) begin
      errors++; $display("FAIL bp_hold got=%h exp=%h", {bus.in_ready_out, head_vec()}, {1'b0, exp_a});
    end
    bus.out_ready_in = 1'b1;
    tick();
    checks++;
    if ({bus.in_ready_out, head_vec()} !== {1'b1, exp_b}) begin
      errors++; $display("FAIL bp_release_b got=%h exp=%h", {bus.in_ready_out, head_vec()}, {1'b1, exp_b});
    end
    tick();
    bus.in_valid_in = 1'b0;
    checks++;
    if (head_vec() !== exp_c) begin
      errors++; $display("FAIL bp_release_c got=%h exp=%h", head_vec(), exp_c);
    end
    tick();
    checks++;
    if ({bus.in_ready_out, bus.out_valid_out} !== 2'b10) begin
      errors++; $display("FAIL bp_drained got=%b exp=10", {bus.in_ready_out, bus.out_valid_out});
    end
  endtask

  task automatic test_flush_reset();
    bus.out_ready_in = 1'b0;
    bus.rs1_data_in  = 32'd5;
    bus.rs2_data_in  = 32'd7;
    drive(32'h002081B3, 32'h0);
    tick();
    drive(32'hFFF00093, 32'h0);
    tick();
    drive(32'h123450B7, 32'h0);
    flush = 1'b1;
    checks++;
    if (bus.in_ready_out !== 1'b0) begin
      errors++; $display("FAIL flush_preflush_ready got=%b exp=0", bus.in_ready_out);
    end
    tick();
    flush = 1'b0;
    bus.in_valid_in = 1'b0;
    checks++;
    if ({bus.in_ready_out, bus.out_valid_out} !== 2'b10) begin
      errors++; $display("FAIL flush_full got=%b exp=10", {bus.in_ready_out, bus.out_valid_out});
    end
    // Flush at count 1 with a genuinely accepted input that must vanish.
    drive(32'h002081B3, 32'h0);
    tick();
    drive(32'h4032D293, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid_in = 1'b0;
    checks++;
    if ({bus.in_ready_out, bus.out_valid_out} !== 2'b10) begin
      errors++; $display("FAIL flush_discard got=%b exp=10", {bus.in_ready_out, bus.out_valid_out});
    end
    tick();
    checks++;
    if (bus.out_valid_out !== 1'b0) begin
      errors++; $display("FAIL flush_not_delivered got=%b exp=0", bus.out_valid_out);
    end
    drive(32'h002081B3, 32'h0);
    tick();
    drive(32'hFFF00093, 32'h0);
    tick();
    drive(32'h123450B7, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid_in = 1'b0;
    checks++;
    if ({bus.in_ready_out, head_vec()} !== {1'b1, 75'd0}) begin
      errors++; $display("FAIL reset_midstream got=%h exp=%h", {bus.in_ready_out, head_vec()}, {1'b1, 75'd0});
    end
  endtask

  initial begin
    bus.in_valid_in  = 1'b0;
    bus.instr_in     = 32'h0;
    bus.pc_in        = 32'h0;
    bus.rs1_data_in  = 32'h0;
    bus.rs2_data_in  = 32'h0;
    bus.out_ready_in = 1'b0;
    test_reset();
    test_basic_decode();
    test_immediates();
    test_upper_imm();
    test_illegal_order();
    test_backpressure();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
